// File: rtl/fifo_pkg.sv
// fifo_pkg: default FIFO geometry and the packed status-flag bundle shared by the FIFO files
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 4;
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read, contents never reset
module fifo_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_fwft.sv
// fifo_sync_fwft: single-clock FIFO, standard or first-word-fall-through read, optional sticky errors.
// Ports: clk, reset (async active-low), din/wr_en write side, rd_en/dout/dout_valid read side,
// count occupancy, empty/full/almost_full/almost_empty status, overflow/underflow sticky errors
// cleared by err_clr. Define FIFO_ERR_FLAGS_EN to enable the sticky error flags.
module fifo_sync_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0] rdata, dout_q;
  logic                  dv_q, empty_w, full_w, wr_ok, rd_ok, ovf, udf;
  fifo_status_t          st;
  assign empty_w = cnt == '0;
  assign full_w  = cnt == DEPTH_C;
  // full blocks the write and empty blocks the read, so simultaneous requests never bypass
  assign wr_ok   = wr_en & ~full_w;
  assign rd_ok   = rd_en & ~empty_w;
  fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_WIDTH'(wr_ok);
      rd_ptr <= rd_ptr + ADDR_WIDTH'(rd_ok);
      cnt    <= cnt + (ADDR_WIDTH+1)'(wr_ok) - (ADDR_WIDTH+1)'(rd_ok);
      dout_q <= rd_ok ? rdata : dout_q;
      dv_q   <= rd_ok;
    end
`ifdef FIFO_ERR_FLAGS_EN
  // a new error in the same cycle as err_clr wins, so no event is lost
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (wr_en & full_w) | (ovf & ~err_clr);
      udf <= (rd_en & empty_w) | (udf & ~err_clr);
    end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif
  assign st = '{empty: empty_w, full: full_w, almost_full: cnt >= AF_C,
                almost_empty: cnt <= AE_C, overflow: ovf, underflow: udf};
  // fall-through mode shows the head word combinationally; zero while empty keeps reset dout at 0
  assign dout         = (FWFT != 0) ? (st.empty ? '0 : rdata) : dout_q;
  assign dout_valid   = (FWFT != 0) ? ~st.empty : dv_q;
  assign count        = cnt;
  assign empty        = st.empty;
  assign full         = st.full;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign overflow     = st.overflow;
  assign underflow    = st.underflow;
endmodule

// File: doc/fifo_sync_fwft.md
FIFO_SYNC_FWFT -- requirements
Module: fifo_sync_fwft

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk and cleared when reset is low.
REQ-002 Parameter DATA_WIDTH, default 16, SHALL set the word width.
REQ-003 Parameter ADDR_WIDTH, default 4, SHALL set the pointer width; DEPTH = 2**ADDR_WIDTH entries, all usable.
REQ-004 Parameter AFULL_THRESH, default DEPTH-2, SHALL set the almost_full level; legal range is 1..DEPTH.
REQ-005 Parameter AEMPTY_THRESH, default 2, SHALL set the almost_empty level; legal range is 0..DEPTH-1.
REQ-006 Parameter FWFT, default 0, SHALL select standard mode (0) or first-word-fall-through mode (1).
REQ-007 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  async active-low reset
- din  in  DATA_WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request (pop in FWFT mode)
- err_clr  in  1  clears sticky error flags
- dout  out  DATA_WIDTH  read data
- dout_valid  out  1  dout qualifier
- count  out  ADDR_WIDTH+1  occupancy
- empty, full, almost_full, almost_empty  out  1 each  status flags
- overflow, underflow  out  1 each  sticky errors

Function
REQ-008 A write SHALL be accepted iff wr_en=1 and full=0; din is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-009 A read SHALL be accepted iff rd_en=1 and empty=0; rd_ptr increments modulo DEPTH.
REQ-010 count SHALL change as follows: +1 on write-only; -1 on read-only; unchanged when both or neither are accepted.
REQ-011 With wr_en=rd_en=1 on an empty FIFO, only the write SHALL be accepted (count 0->1, no bypass).
REQ-012 With wr_en=rd_en=1 on a full FIFO, only the read SHALL be accepted (count DEPTH->DEPTH-1).
REQ-013 Status flags SHALL decode combinationally from registered count:
- empty = (count==0)
- full = (count==DEPTH)
- almost_full = (count>=AFULL_THRESH)
- almost_empty = (count<=AEMPTY_THRESH)
REQ-014 In standard mode (FWFT=0), dout SHALL load mem[rd_ptr] on the edge of an accepted read and hold otherwise.
REQ-015 In standard mode, dout_valid SHALL be 1 for exactly the cycle following each accepted read.
REQ-016 In FWFT mode (FWFT=1), dout SHALL present mem[rd_ptr] whenever empty=0, with dout_valid = ~empty; a word written into an empty FIFO SHALL be visible the cycle after its write edge.
REQ-017 Pointer wrap SHALL be seamless: data order is preserved across any number of wraps.

Reset
REQ-018 Reset SHALL force:
- wr_ptr, rd_ptr and count to 0
- dout to 0 and dout_valid to 0
- overflow and underflow to 0
- hence empty=1, full=0, almost_empty=1, almost_full=0
REQ-019 Reset asserted mid-operation SHALL discard all contents immediately; memory array contents SHALL NOT be reset.

Configuration
REQ-020 With macro FIFO_ERR_FLAGS_EN defined:
- overflow SHALL set on wr_en=1 while full=1
- underflow SHALL set on rd_en=1 while empty=1
- both SHALL stay set until err_clr=1 or reset
- a set condition coinciding with err_clr SHALL leave the flag set
REQ-021 Without FIFO_ERR_FLAGS_EN, overflow and underflow SHALL be tied to 0 and err_clr SHALL be ignored.

Structure
REQ-022 Package fifo_pkg SHALL hold the default width/depth constants and typedef fifo_status_t (empty, full, almost_full, almost_empty, overflow, underflow).
REQ-023 Storage SHALL be sub-module fifo_ram: DEPTH x DATA_WIDTH, synchronous write, asynchronous read.

Verification (DATA_WIDTH=16, ADDR_WIDTH=3, DEPTH=8, AFULL=6, AEMPTY=2)
REQ-024 Write 0x0001..0x0008 -> full=1 and count=8 after the 8th edge; a 9th write of 0xDEAD is dropped, with overflow=1 if FIFO_ERR_FLAGS_EN.
REQ-025 Standard mode: after 8 writes, issue 8 reads -> dout=0x0001..0x0008 each one cycle after its read with dout_valid pulses; empty=1 at end.
REQ-026 FWFT mode: single write 0x00AA into an empty FIFO -> dout=0x00AA and dout_valid=1 the next cycle; rd_en pops it -> empty=1.
REQ-027 Simultaneous wr/rd: on empty, count 0->1; at count=8, count 8->7; at count=4, count stays 4; almost_full toggles at 6 and almost_empty at 2.
REQ-028 Stream 20 words with random rd/wr gaps -> output order matches input across pointer wraps; async reset pulse mid-stream -> count=0, dout=0, dout_valid=0 immediately.
